// File: rtl/fence_controller.sv
// FENCE / FENCE.I sequencer: stalls fetch, drains the LSU and store buffer, and for
// FENCE.I invalidates the I-cache and flushes the pipeline to pc+4 before reporting done.
package fence_pkg;
    typedef enum logic [1:0] {
        fk_fence   = 2'd0,
        fk_fence_i = 2'd1,
        fk_invalid = 2'd2
    } fence_kind_t;
endpackage

module fence_controller
    import fence_pkg::*;
#(
    parameter int CNT_W         = 4,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int TO_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  fence_kind_t       req_kind,
    input  logic [31:0]       req_pc,
    input  logic [CNT_W-1:0]  lsu_pending,
    input  logic              sb_empty,
    output logic              icache_inv_req,
    input  logic              icache_inv_ack,
    output logic              flush_valid,
    output logic [31:0]       flush_pc,
    output logic              stall_fetch,
    output logic              done_valid,
    output logic              done_err,
    output logic              done_illegal
);
    typedef enum logic [2:0] {IDLE, DRAIN, INV, FLUSH, DONE} state_t;

    // Counter value on the last tolerated undrained DRAIN cycle; unused when the timeout is off.
    localparam logic [TO_W-1:0] TO_LIMIT =
        (DRAIN_TIMEOUT == 0) ? '0 : TO_W'(DRAIN_TIMEOUT - 1);

    state_t          state, state_next;
    logic [TO_W-1:0] to_cnt, to_cnt_next;
    logic            is_fence_i;
    logic            accept;
    logic            drained;
    logic            kind_ok;
    logic            timeout;

    assign req_ready   = (state == IDLE) && !rst;
    assign stall_fetch = (state != IDLE);
    assign accept      = req_valid && req_ready;
    assign drained     = (lsu_pending == '0) && sb_empty;
    assign kind_ok     = (req_kind == fk_fence) || (req_kind == fk_fence_i);

    always_comb begin
        state_next  = state;
        to_cnt_next = to_cnt;
        timeout     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    to_cnt_next = '0;
                    state_next  = kind_ok ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                // A drained sample wins over a timeout landing in the same cycle.
                if (drained) begin
                    state_next = is_fence_i ? INV : DONE;
                end else if (DRAIN_TIMEOUT != 0) begin
                    if (to_cnt == TO_LIMIT) begin
                        timeout    = 1'b1;
                        state_next = DONE;
                    end else begin
                        to_cnt_next = to_cnt + TO_W'(1);
                    end
                end
            end
            INV: begin
                if (icache_inv_ack) begin
                    state_next = FLUSH;
                end
            end
            FLUSH:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each is valid for the whole cycle it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            to_cnt         <= '0;
            is_fence_i     <= 1'b0;
            icache_inv_req <= 1'b0;
            flush_valid    <= 1'b0;
            flush_pc       <= '0;
            done_valid     <= 1'b0;
            done_err       <= 1'b0;
            done_illegal   <= 1'b0;
        end else begin
            state          <= state_next;
            to_cnt         <= to_cnt_next;
            icache_inv_req <= (state_next == INV);
            flush_valid    <= (state_next == FLUSH);
            done_valid     <= (state_next == DONE);
            if (accept) begin
                is_fence_i   <= (req_kind == fk_fence_i);
                flush_pc     <= req_pc + 32'd4;
                done_err     <= 1'b0;
                done_illegal <= !kind_ok;
            end
            if (timeout) begin
                done_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fence_controller.sv
// Self-checking bench for fence_controller: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed latencies and flush addresses.
module tb_fence_controller;
    import fence_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    fence_kind_t req_kind;
    logic [31:0] req_pc;
    logic [3:0]  lsu_pending;
    logic        sb_empty;
    logic        icache_inv_ack;
    logic        req_ready;
    logic        icache_inv_req;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic        stall_fetch;
    logic        done_valid;
    logic        done_err;
    logic        done_illegal;

    // Second instance with the timeout disabled, driven independently.
    logic        z_rst;
    logic        z_req_valid;
    fence_kind_t z_kind;
    logic [31:0] z_pc;
    logic [3:0]  z_lsu;
    logic        z_sb;
    logic        z_ack;
    logic        z_req_ready;
    logic        z_inv;
    logic        z_flush_valid;
    logic [31:0] z_flush_pc;
    logic        z_stall;
    logic        z_done_valid;
    logic        z_done_err;
    logic        z_done_illegal;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    int          n_flush = 0;
    int          n_inv   = 0;
    int          n_done  = 0;
    int          z_done  = 0;
    logic [31:0] last_fpc = '0;
    logic        last_err = 1'b0;
    logic        last_ill = 1'b0;

    fence_controller #(.CNT_W(4), .DRAIN_TIMEOUT(TO), .TO_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_pc(req_pc), .lsu_pending(lsu_pending), .sb_empty(sb_empty),
        .icache_inv_req(icache_inv_req), .icache_inv_ack(icache_inv_ack),
        .flush_valid(flush_valid), .flush_pc(flush_pc), .stall_fetch(stall_fetch),
        .done_valid(done_valid), .done_err(done_err), .done_illegal(done_illegal)
    );

    fence_controller #(.CNT_W(4), .DRAIN_TIMEOUT(0), .TO_W(16)) dut_noto (
        .clk(clk), .rst(z_rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_kind(z_kind), .req_pc(z_pc), .lsu_pending(z_lsu), .sb_empty(z_sb),
        .icache_inv_req(z_inv), .icache_inv_ack(z_ack),
        .flush_valid(z_flush_valid), .flush_pc(z_flush_pc), .stall_fetch(z_stall),
        .done_valid(z_done_valid), .done_err(z_done_err), .done_illegal(z_done_illegal)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Model: the current phase of the one transaction in flight, advanced per clock edge.
    string       m_stage = "idle";
    bit          m_fi    = 1'b0;
    bit          m_err   = 1'b0;
    bit          m_ill   = 1'b0;
    logic [31:0] m_fpc   = '0;
    int          m_wait  = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_stage = "idle";
            m_err   = 1'b0;
            m_ill   = 1'b0;
        end else if (m_stage == "idle") begin
            if (req_valid) begin
                m_ill   = !(req_kind == fk_fence || req_kind == fk_fence_i);
                m_err   = 1'b0;
                m_fi    = (req_kind == fk_fence_i);
                m_fpc   = req_pc + 32'd4;
                m_wait  = 0;
                m_stage = m_ill ? "done" : "drain";
            end
        end else if (m_stage == "drain") begin
            if (lsu_pending == 4'd0 && sb_empty) begin
                m_stage = m_fi ? "inv" : "done";
            end else begin
                m_wait++;
                if (m_wait == TO) begin
                    m_err   = 1'b1;
                    m_stage = "done";
                end
            end
        end else if (m_stage == "inv") begin
            if (icache_inv_ack) m_stage = "flush";
        end else if (m_stage == "flush") begin
            m_stage = "done";
        end else begin
            m_stage = "idle";
        end
    end

    // Every-cycle comparison against the model, plus event tallies for the directed checks.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("req_ready",      32'(req_ready),      32'((m_stage == "idle") && !rst));
            checkOutput("stall_fetch",    32'(stall_fetch),    32'(m_stage != "idle"));
            checkOutput("icache_inv_req", 32'(icache_inv_req), 32'(m_stage == "inv"));
            checkOutput("flush_valid",    32'(flush_valid),    32'(m_stage == "flush"));
            checkOutput("done_valid",     32'(done_valid),     32'(m_stage == "done"));
            checkOutput("done_err",       32'(done_err),       32'(m_err));
            checkOutput("done_illegal",   32'(done_illegal),   32'(m_ill));
            if (m_stage == "flush") checkOutput("flush_pc", flush_pc, m_fpc);
        end
        if (flush_valid === 1'b1) begin
            n_flush++;
            last_fpc = flush_pc;
        end
        if (icache_inv_req === 1'b1) n_inv++;
        if (done_valid === 1'b1) begin
            n_done++;
            last_err = done_err;
            last_ill = done_illegal;
        end
        if (z_done_valid === 1'b1) z_done++;
    end

    // Issues one request in the current cycle and returns the cycle index of done_valid (0 = none).
    task automatic applyStimulus(input fence_kind_t kind, input logic [31:0] pc,
                                 input int max_cyc, output int lat);
        req_valid = 1'b1;
        req_kind  = kind;
        req_pc    = pc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_kind  = fk_invalid;
        req_pc    = $urandom;
        lat = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (done_valid) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL done_wait: no done_valid within %0d cycles, required one", max_cyc);
        end
        @(posedge clk); #1;
    endtask

    int lat;
    int f0, i0, d0;

    initial begin
        rst = 1'b1; z_rst = 1'b1;
        req_valid = 1'b0; req_kind = fk_fence; req_pc = '0;
        lsu_pending = 4'd0; sb_empty = 1'b1; icache_inv_ack = 1'b0;
        z_req_valid = 1'b0; z_kind = fk_fence; z_pc = 32'h80; z_lsu = 4'd0; z_sb = 1'b0; z_ack = 1'b0;

        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_stall", 32'(stall_fetch), 32'd0);
        checkOutput("rst_done",  32'(done_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; z_rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst",   32'(req_ready), 32'd1);
        checkOutput("z_ready_after_rst", 32'(z_req_ready), 32'd1);
        @(posedge clk); #1;
        z_req_valid = 1'b1;
        @(posedge clk); #1;
        z_req_valid = 1'b0;

        // Plain fence, already drained.
        f0 = n_flush; i0 = n_inv;
        applyStimulus(fk_fence, 32'h0000_0100, 20, lat);
        checkOutput("fence_lat",     32'(lat), 32'd2);
        checkOutput("fence_err",     32'(last_err), 32'd0);
        checkOutput("fence_illegal", 32'(last_ill), 32'd0);
        checkOutput("fence_noflush", 32'(n_flush - f0), 32'd0);
        checkOutput("fence_noinv",   32'(n_inv - i0), 32'd0);

        // Fence waiting on LSU: pending for cycles 0..4, drained from cycle 5.
        lsu_pending = 4'd3;
        fork
            applyStimulus(fk_fence, 32'h0000_0200, 30, lat);
            begin
                repeat (5) begin @(posedge clk); #1; end
                lsu_pending = 4'd0;
            end
        join
        checkOutput("drain_wait_lat", 32'(lat), 32'd6);

        // FENCE.I with ack arriving in the fourth INV cycle.
        f0 = n_flush; i0 = n_inv;
        fork
            applyStimulus(fk_fence_i, 32'h0000_1000, 30, lat);
            begin
                repeat (5) begin @(posedge clk); #1; end
                icache_inv_ack = 1'b1;
                @(posedge clk); #1;
                icache_inv_ack = 1'b0;
            end
        join
        checkOutput("fencei_lat",      32'(lat), 32'd7);
        checkOutput("fencei_flush_pc", last_fpc, 32'h0000_1004);
        checkOutput("fencei_flushes",  32'(n_flush - f0), 32'd1);
        checkOutput("fencei_inv_cyc",  32'(n_inv - i0), 32'd4);

        // Ack held high throughout (same-cycle ack, ignored outside INV) and pc wrap.
        icache_inv_ack = 1'b1;
        i0 = n_inv;
        applyStimulus(fk_fence_i, 32'hFFFF_FFFC, 20, lat);
        checkOutput("wrap_lat",      32'(lat), 32'd4);
        checkOutput("wrap_flush_pc", last_fpc, 32'h0000_0000);
        checkOutput("wrap_inv_cyc",  32'(n_inv - i0), 32'd1);
        icache_inv_ack = 1'b0;

        // Drain timeout: store buffer never empties.
        sb_empty = 1'b0;
        f0 = n_flush; i0 = n_inv;
        applyStimulus(fk_fence_i, 32'h0000_0300, 30, lat);
        checkOutput("timeout_lat",     32'(lat), 32'd9);
        checkOutput("timeout_err",     32'(last_err), 32'd1);
        checkOutput("timeout_noflush", 32'(n_flush - f0), 32'd0);
        checkOutput("timeout_noinv",   32'(n_inv - i0), 32'd0);

        // Drained on the very cycle the timeout would fire: completes normally.
        icache_inv_ack = 1'b1;
        fork
            applyStimulus(fk_fence_i, 32'h0000_0400, 30, lat);
            begin
                repeat (8) begin @(posedge clk); #1; end
                sb_empty = 1'b1;
            end
        join
        checkOutput("edge_drain_lat", 32'(lat), 32'd11);
        checkOutput("edge_drain_err", 32'(last_err), 32'd0);
        checkOutput("edge_flush_pc",  last_fpc, 32'h0000_0404);
        icache_inv_ack = 1'b0;

        // Illegal kind, then an immediate back-to-back fence.
        f0 = n_flush;
        applyStimulus(fk_invalid, 32'h0000_0500, 10, lat);
        checkOutput("illegal_lat",     32'(lat), 32'd1);
        checkOutput("illegal_flag",    32'(last_ill), 32'd1);
        checkOutput("illegal_noflush", 32'(n_flush - f0), 32'd0);
        @(negedge clk);
        checkOutput("ready_after_illegal", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        applyStimulus(fk_fence, 32'h0000_0600, 10, lat);
        checkOutput("post_illegal_lat",  32'(lat), 32'd2);
        checkOutput("post_illegal_flag", 32'(last_ill), 32'd0);

        // Reset in the middle of INV.
        d0 = n_done;
        req_valid = 1'b1; req_kind = fk_fence_i; req_pc = 32'h0000_0700;
        @(posedge clk); #1;
        req_valid = 1'b0; req_kind = fk_invalid;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("inv_before_rst", 32'(icache_inv_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rst_mid_inv",   32'(icache_inv_req), 32'd0);
        checkOutput("rst_mid_stall", 32'(stall_fetch), 32'd0);
        checkOutput("rst_mid_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_ready_after", 32'(req_ready), 32'd1);
        checkOutput("rst_mid_nodone",      32'(n_done - d0), 32'd0);
        @(posedge clk); #1;
        icache_inv_ack = 1'b1;
        applyStimulus(fk_fence_i, 32'h0000_0800, 20, lat);
        checkOutput("after_rst_lat",      32'(lat), 32'd4);
        checkOutput("after_rst_flush_pc", last_fpc, 32'h0000_0804);
        checkOutput("after_rst_err",      32'(last_err), 32'd0);
        icache_inv_ack = 1'b0;

        // The timeout-disabled instance has sat undrained for far longer than any timeout.
        @(negedge clk);
        checkOutput("noto_no_done", 32'(z_done), 32'd0);
        checkOutput("noto_stall",   32'(z_stall), 32'd1);
        checkOutput("noto_ready",   32'(z_req_ready), 32'd0);
        checkOutput("noto_noinv",   32'(z_inv), 32'd0);
        checkOutput("noto_noflush", 32'(z_flush_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
